dht11_responder: RTL

- Emulates the sensor side of the DHT11 single-wire protocol.
- Detects the host start pulse on the shared data line, then drives back the response preamble and a 40-bit frame (humidity, temperature, checksum) with DHT11 timing.
- Used as a board-level sensor stand-in and as the bench partner for the DHT11 host logic in the fan info path.
- Open-drain: the block only ever pulls the line low; the top level builds the inout from dq_oe.

---
 rtl/dht11_responder.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/dht11_responder.sv
// DHT11 sensor-side emulator: waits for a host start pulse on the open-drain line,
// then answers with the response preamble and a 40-bit humidity/temperature frame.
module dht11_responder #(
    parameter int unsigned SYS_FREQ     = 125,
    parameter int unsigned START_MIN_US = 18000,
    parameter int unsigned WAIT_US      = 30,
    parameter int unsigned RESP_US      = 80,
    parameter int unsigned BIT_LOW_US   = 50,
    parameter int unsigned ZERO_US      = 27,
    parameter int unsigned ONE_US       = 70
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       dq_in,
    input  logic [7:0] hum_int,
    input  logic [7:0] hum_dec,
    input  logic [7:0] temp_int,
    input  logic [7:0] temp_dec,
    input  logic       csum_err_inject,
    output logic       dq_oe,
    output logic       busy,
    output logic       frame_done,
    output logic       start_err
);

    localparam int unsigned PW = (SYS_FREQ > 1) ? $clog2(SYS_FREQ) : 1;

    typedef enum logic [2:0] {
        IDLE, HOST_LOW, WAIT_REL, RESP_LOW, RESP_HIGH, BIT_LOW, BIT_HIGH, END_LOW
    } state_t;

    state_t        r_state, w_next;
    logic          r_dq_s1, r_dq_s, r_dq_d, r_armed;
    logic [PW-1:0] r_pre;
    logic [15:0]   r_us;
    logic [39:0]   r_frame;
    logic [5:0]    r_idx;
    logic          w_fall, w_rise, w_tick, w_end;
    logic          w_oe_nxt, w_busy_nxt, w_done_nxt, w_err_nxt;
    logic [15:0]   w_len;
    logic [7:0]    w_csum;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_dq_s1 <= 1'b1;
            r_dq_s  <= 1'b1;
            r_dq_d  <= 1'b1;
        end else begin
            r_dq_s1 <= dq_in;
            r_dq_s  <= r_dq_s1;
            r_dq_d  <= r_dq_s;
        end
    end

    assign w_fall = r_dq_d & ~r_dq_s;
    assign w_rise = ~r_dq_d & r_dq_s;
    assign w_tick = (r_pre == PW'(SYS_FREQ - 1));
    assign w_end  = w_tick && (r_us == w_len - 16'd1);
    assign w_csum = (hum_int + hum_dec + temp_int + temp_dec) ^ {7'd0, csum_err_inject};

    // Timer restarts on every state change so each phase is an exact multiple of 1 us.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pre <= '0;
            r_us  <= '0;
        end else if (w_next != r_state) begin
            r_pre <= '0;
            r_us  <= '0;
        end else if (w_tick) begin
            r_pre <= '0;
            if (r_us != '1) r_us <= r_us + 16'd1;
        end else begin
            r_pre <= r_pre + PW'(1);
        end
    end

    always_comb begin
        w_len = 16'(BIT_LOW_US);
        case (r_state)
            WAIT_REL:            w_len = 16'(WAIT_US);
            RESP_LOW, RESP_HIGH: w_len = 16'(RESP_US);
            BIT_HIGH:            w_len = r_frame[r_idx] ? 16'(ONE_US) : 16'(ZERO_US);
            default:             w_len = 16'(BIT_LOW_US);
        endcase
    end

    always_comb begin
        w_next     = r_state;
        w_done_nxt = 1'b0;
        w_err_nxt  = 1'b0;
        case (r_state)
            IDLE:      if (r_armed && w_fall && !dq_oe) w_next = HOST_LOW;
            HOST_LOW:  if (w_rise) begin
                           if (r_us >= 16'(START_MIN_US)) begin
                               w_next = WAIT_REL;
                           end else begin
                               w_next    = IDLE;
                               w_err_nxt = 1'b1;
                           end
                       end
            WAIT_REL:  if (w_end) w_next = RESP_LOW;
            RESP_LOW:  if (w_end) w_next = RESP_HIGH;
            RESP_HIGH: if (w_end) w_next = BIT_LOW;
            BIT_LOW:   if (w_end) w_next = BIT_HIGH;
            BIT_HIGH:  if (w_end) w_next = (r_idx == 6'd0) ? END_LOW : BIT_LOW;
            END_LOW:   if (w_end) begin
                           w_next     = IDLE;
                           w_done_nxt = 1'b1;
                       end
            default:   w_next = IDLE;
        endcase
        w_oe_nxt   = (w_next == RESP_LOW) || (w_next == BIT_LOW) || (w_next == END_LOW);
        w_busy_nxt = (w_next != IDLE) && (w_next != HOST_LOW);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            dq_oe      <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            start_err  <= 1'b0;
        end else begin
            r_state    <= w_next;
            dq_oe      <= w_oe_nxt;
            busy       <= w_busy_nxt;
            frame_done <= w_done_nxt;
            start_err  <= w_err_nxt;
        end
    end

    // Arms only after the line has been seen high in IDLE, so a line still low on re-entry cannot start.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_armed <= 1'b0;
        end else begin
            r_armed <= (r_state == IDLE) && (w_next == IDLE) && (r_armed || r_dq_s);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_frame <= '0;
            r_idx   <= '0;
        end else begin
            if (r_state == WAIT_REL && w_end)
                r_frame <= {hum_int, hum_dec, temp_int, temp_dec, w_csum};
            if (r_state == RESP_HIGH && w_end)
                r_idx <= 6'd39;
            else if (r_state == BIT_HIGH && w_end && r_idx != 6'd0)
                r_idx <= r_idx - 6'd1;
        end
    end

endmodule
